rx_frame_packer: RTL and testbench
==================================

Name: rx_frame_packer

Overview:
- Upstream neighbour of packet_receiver, on the Ethernet receive path.
- Takes the MAC receive byte stream (one byte per cycle, no backpressure) and packs it into 32-bit words with SOF/EOF/occupancy flags.
- Stores complete frames in a store-and-forward FIFO. Frames with errors or overflow are discarded.
- Presents committed frames on the rd_* word interface that packet_receiver consumes.

Parameters:
ADDR_W, 9, log2 of FIFO depth in words. Each entry is 36 bits: {flags[3:0], data[31:0]}. Usable capacity is 2^ADDR_W-1 words.
DROP_W, 16, width of the dropped-frame counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data_i  in  8  receive byte
rx_dv_i  in  1  byte valid; high for the whole frame, low between frames
rx_er_i  in  1  receive error; sampled while rx_dv_i is high
rd_data_o  out  32  packed word; first frame byte is in [31:24]
rd_flags_o  out  4  [0]=SOF, [1]=EOF, [3:2]=occupancy of EOF word (00=4 bytes, 01=1, 10=2, 11=3)
rd_src_rdy_o  out  1  word valid
rd_dst_rdy_i  in  1  consumer ready; a word transfers when src_rdy and dst_rdy are both high
drop_count_o  out  DROP_W  saturating count of discarded frames

Behaviour:
- Reset values: rd_src_rdy_o=0, rd_data_o=0, rd_flags_o=0, drop_count_o=0. All pointers are 0. Write FSM is in WAIT_IDLE.
- Write FSM states:
  - WAIT_IDLE: stay until rx_dv_i=0, then go to IDLE. This state is entered after reset or after a discard, so a frame already in flight is never captured partially.
  - IDLE: when rx_dv_i=1, go to RECV. The current byte is byte 0 and is placed in [31:24].
  - RECV: bytes fill [31:24],[23:16],[15:8],[7:0] in order using a 2-bit byte counter.
    - When the 4th byte lands, the word is written at wr_ptr and wr_ptr increments. SOF is set only on the frame's first word.
    - A copy of the last full word is kept for EOF patching.
  - END: entered on the first cycle with rx_dv_i=0 in RECV. Performs exactly one RAM write:
    - Partial word pending (counter≠0): write the partial word with EOF and occupancy = counter. Unused low bytes are 0. wr_ptr increments.
    - Counter=0: rewrite entry wr_ptr-1 with the same data plus EOF and occupancy 00. SOF is kept if the frame is a single word.
    - Next cycle: commit_ptr <= wr_ptr; go to IDLE.
  - DISCARD: entered from RECV on rx_er_i=1 or on a write attempt while full (wr_ptr+1==rd_ptr).
    - wr_ptr <= commit_ptr.
    - drop_count_o increments, saturating at all-ones.
    - Go to WAIT_IDLE.
- A frame larger than the usable capacity is always discarded.
- 1-byte frame: single word with flags 4'b0111.
- Read side only ever sees entries below commit_ptr, so no partial frame is visible to the consumer.
- Output register is first-word-fall-through:
  - rd_src_rdy_o asserts at most 3 cycles after commit_ptr advances past rd_ptr.
  - On a transfer, the next word is presented on the following cycle with no bubble while data is available.
  - rd_data_o and rd_flags_o hold stable while rd_src_rdy_o=1 and rd_dst_rdy_i=0.
- Pointers wrap modulo 2^ADDR_W.
- Reading and writing in the same cycle are both allowed. Full/empty are evaluated on pre-update pointers.
- Reset asserted mid-frame or mid-read flushes the whole FIFO. No word is emitted after reset until a new complete frame is committed.

Optional Feature:
- Macro: RX_FCS_STRIP_EN.
- Defined: incoming bytes pass through a 4-byte delay line, so the last 4 bytes of each frame (FCS) are never written.
  - Occupancy and EOF apply to the last non-FCS byte.
  - Frames of 4 bytes or fewer are discarded and counted in drop_count_o.
  - Capture latency grows by 4 byte times.
- Undefined: all bytes are passed through unchanged.

Test Plan:
All scenarios run with the macro undefined unless stated.
1. 8-byte frame 01..08 -> two words: 0x01020304 with flags 0001, then 0x05060708 with flags 0010.
2. 5-byte frame AA BB CC DD EE -> 0xAABBCCDD with flags 0001, then 0xEE000000 with flags 0110.
3. 1-byte frame 0x41 -> single word 0x41000000 with flags 0111. Back-to-back with a 12-byte gap, a following 4-byte frame -> its single word has flags 0011.
4. 10-byte frame with rx_er_i high on byte 3, followed by the good frame of scenario 1 -> only the two scenario-1 words emerge; drop_count_o=1.
5. ADDR_W=4, rd_dst_rdy_i=0: send a 40-byte frame, then a 60-byte frame, then raise rd_dst_rdy_i -> exactly 10 words emerge (first frame); second frame dropped; drop_count_o=1. Toggle rd_dst_rdy_i every cycle -> no word lost or duplicated.
6. With RX_FCS_STRIP_EN defined: a 68-byte frame -> 16 words, last word flags 0010. A 4-byte frame -> no output, drop_count_o increments. Separately, assert reset mid-frame -> no output until the next complete frame.

Source files
------------

// File: rtl/rx_frame_packer.sv
// Packs the MAC byte stream into 36-bit {flags,data} words inside a store-and-forward FIFO.
// Define RX_FCS_STRIP_EN to drop the trailing 4-byte FCS of every frame before packing.
module rx_frame_packer #(
  parameter int ADDR_W = 9,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_dv_i,
  input  logic              rx_er_i,
  output logic [31:0]       rd_data_o,
  output logic [3:0]        rd_flags_o,
  output logic              rd_src_rdy_o,
  input  logic              rd_dst_rdy_i,
  output logic [DROP_W-1:0] drop_count_o
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_RECV,
    S_END,
    S_DISCARD
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_commit_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [31:0]       r_word;
  logic [1:0]        r_cnt;
  logic              r_first;
  logic [31:0]       r_last;
  logic              r_last_sof;
  logic [DROP_W-1:0] r_drop;
  logic [35:0]       r_out;
  logic              r_out_vld;
  logic [35:0]       r_mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] w_wr_ptr_nx;
  logic [ADDR_W-1:0] w_commit_nx;
  logic [31:0]       w_word_nx;
  logic [1:0]        w_cnt_nx;
  logic              w_first_nx;
  logic [31:0]       w_last_nx;
  logic              w_last_sof_nx;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [35:0]       w_wdata;
  logic              w_drop_inc;
  logic [31:0]       w_merged;
  logic              w_full;
  logic              w_avail;
  logic              w_load;
  logic              w_xfer;

  logic              w_dv;
  logic [7:0]        w_byte;
  logic              w_er;
  logic              w_short;

`ifdef RX_FCS_STRIP_EN
  // Bytes are released only once four newer ones are behind them
  logic [31:0] r_dly;
  logic [2:0]  r_fill;
  logic        r_er_stk;
  logic        r_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dly    <= '0;
      r_fill   <= '0;
      r_er_stk <= 1'b0;
      r_seen   <= 1'b0;
    end else if (rx_dv_i) begin
      r_dly    <= {r_dly[23:0], rx_data_i};
      r_er_stk <= r_er_stk | rx_er_i;
      if (r_fill != 3'd4)
        r_fill <= r_fill + 3'd1;
      if (w_dv)
        r_seen <= 1'b1;
    end else begin
      r_fill   <= '0;
      r_er_stk <= 1'b0;
      r_seen   <= 1'b0;
    end
  end

  assign w_dv    = rx_dv_i && (r_fill == 3'd4);
  assign w_byte  = r_dly[31:24];
  assign w_er    = w_dv && (r_er_stk || rx_er_i);
  assign w_short = !rx_dv_i && (r_fill != 3'd0) && !r_seen;
`else
  assign w_dv    = rx_dv_i;
  assign w_byte  = rx_data_i;
  assign w_er    = rx_dv_i && rx_er_i;
  assign w_short = 1'b0;
`endif

  assign w_merged = r_word | ({24'h0, w_byte} << {~r_cnt, 3'b000});
  assign w_full   = (r_wr_ptr + PTR_ONE) == r_rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_word       <= '0;
      r_cnt        <= '0;
      r_first      <= 1'b0;
      r_last       <= '0;
      r_last_sof   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_wr_ptr     <= w_wr_ptr_nx;
      r_commit_ptr <= w_commit_nx;
      r_word       <= w_word_nx;
      r_cnt        <= w_cnt_nx;
      r_first      <= w_first_nx;
      r_last       <= w_last_nx;
      r_last_sof   <= w_last_sof_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_wr_ptr_nx   = r_wr_ptr;
    w_commit_nx   = r_commit_ptr;
    w_word_nx     = r_word;
    w_cnt_nx      = r_cnt;
    w_first_nx    = r_first;
    w_last_nx     = r_last;
    w_last_sof_nx = r_last_sof;
    w_we          = 1'b0;
    w_waddr       = r_wr_ptr;
    w_wdata       = '0;
    w_drop_inc    = w_short && (r_state == S_IDLE);
    unique case (r_state)
      S_WAIT_IDLE: begin
        if (!rx_dv_i)
          w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (w_dv) begin
          if (w_er) begin
            w_state_nx = S_DISCARD;
          end else begin
            w_state_nx = S_RECV;
            w_word_nx  = {w_byte, 24'h0};
            w_cnt_nx   = 2'd1;
            w_first_nx = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (!w_dv) begin
          w_state_nx = S_END;
        end else if (w_er) begin
          w_state_nx = S_DISCARD;
        end else if (r_cnt == 2'd3) begin
          if (w_full) begin
            w_state_nx = S_DISCARD;
          end else begin
            w_we          = 1'b1;
            w_wdata       = {3'b000, r_first, w_merged};
            w_wr_ptr_nx   = r_wr_ptr + PTR_ONE;
            w_last_nx     = w_merged;
            w_last_sof_nx = r_first;
            w_first_nx    = 1'b0;
            w_word_nx     = '0;
            w_cnt_nx      = 2'd0;
          end
        end else begin
          w_word_nx = w_merged;
          w_cnt_nx  = r_cnt + 2'd1;
        end
      end
      S_END: begin
        // A word-aligned frame patches EOF into its last full word
        if (r_cnt != 2'd0) begin
          if (w_full) begin
            w_state_nx = S_DISCARD;
          end else begin
            w_we        = 1'b1;
            w_wdata     = {r_cnt, 1'b1, r_first, r_word};
            w_wr_ptr_nx = r_wr_ptr + PTR_ONE;
            w_commit_nx = r_wr_ptr + PTR_ONE;
            w_state_nx  = S_IDLE;
          end
        end else begin
          w_we        = 1'b1;
          w_waddr     = r_wr_ptr - PTR_ONE;
          w_wdata     = {2'b00, 1'b1, r_last_sof, r_last};
          w_commit_nx = r_wr_ptr;
          w_state_nx  = S_IDLE;
        end
      end
      S_DISCARD: begin
        w_wr_ptr_nx = r_commit_ptr;
        w_drop_inc  = 1'b1;
        w_state_nx  = S_WAIT_IDLE;
      end
      default: begin
        w_state_nx = S_WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop <= '0;
    else if (w_drop_inc && (r_drop != {DROP_W{1'b1}}))
      r_drop <= r_drop + DROP_ONE;
  end

  // Output register refills in the same cycle it is drained
  assign w_avail = r_rd_ptr != r_commit_ptr;
  assign w_xfer  = r_out_vld && rd_dst_rdy_i;
  assign w_load  = w_avail && (!r_out_vld || rd_dst_rdy_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else if (w_load) begin
      r_out     <= r_mem[r_rd_ptr];
      r_out_vld <= 1'b1;
      r_rd_ptr  <= r_rd_ptr + PTR_ONE;
    end else if (w_xfer) begin
      r_out_vld <= 1'b0;
    end
  end

  assign rd_data_o    = r_out[31:0];
  assign rd_flags_o   = r_out[35:32];
  assign rd_src_rdy_o = r_out_vld;
  assign drop_count_o = r_drop;

endmodule

// File: tb/tb_rx_frame_packer.sv
// Scoreboard bench for rx_frame_packer: directed frames push expected words,
// a negedge monitor pops and compares every transferred word.
module tb_rx_frame_packer;

`ifdef RX_FCS_STRIP_EN
  localparam int AW = 5;
`else
  localparam int AW = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [31:0] rd_data;
  logic [3:0]  rd_flags;
  logic        rd_src_rdy;
  logic        rd_dst_rdy = 1'b1;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [35:0] hold_val = '0;

  rx_frame_packer #(.ADDR_W(AW), .DROP_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data_i    (rx_data),
    .rx_dv_i      (rx_dv),
    .rx_er_i      (rx_er),
    .rd_data_o    (rd_data),
    .rd_flags_o   (rd_flags),
    .rd_src_rdy_o (rd_src_rdy),
    .rd_dst_rdy_i (rd_dst_rdy),
    .drop_count_o (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_checks++;
        if (!rd_src_rdy || {rd_flags, rd_data} !== hold_val) begin
          n_errors++;
          $display("FAIL hold: got vld=%0b %h want %h",
                   rd_src_rdy, {rd_flags, rd_data}, hold_val);
        end
      end
      if (rd_src_rdy && rd_dst_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_word: got %h want none",
                   {rd_flags, rd_data});
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          if ({rd_flags, rd_data} !== e) begin
            n_errors++;
            $display("FAIL word: got %h want %h", {rd_flags, rd_data}, e);
          end
        end
      end
      hold_pend = rd_src_rdy && !rd_dst_rdy;
      hold_val  = {rd_flags, rd_data};
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push_gen(input int n, input logic [7:0] base,
                          input logic [7:0] step);
    int nw;
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      logic [3:0]  f;
      d = '0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < n)
          d[31-8*k -: 8] = base + 8'(w * 4 + k) * step;
      f = 4'b0000;
      f[0] = (w == 0);
      if (w == nw - 1) begin
        f[1]   = 1'b1;
        f[3:2] = 2'(n % 4);
      end
      exp_q.push_back({f, d});
    end
  endtask

  task automatic send_rst(input int n, input logic [7:0] base,
                          input logic [7:0] step, input int err_at,
                          input int rst_at, input int gap);
    logic [7:0] b;
    b = base;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == rst_at) reset = 1'b1;
      if (i == rst_at + 2) reset = 1'b0;
      rx_dv   = 1'b1;
      rx_data = b;
      rx_er   = (i == err_at);
      b = b + step;
    end
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_er = 1'b0; rx_data = '0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send(input int n, input logic [7:0] base,
                      input logic [7:0] step, input int err_at);
    send_rst(n, base, step, err_at, -10, 12);
  endtask

  task automatic drain(input string nm, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (5) @(posedge clk);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_src_rdy", {31'h0, rd_src_rdy}, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_flags", {28'h0, rd_flags}, 0);
    chk("rst_drop", {16'h0, drop_count}, 0);

`ifdef RX_FCS_STRIP_EN
    push_gen(64, 8'h00, 8'h01);
    send(68, 8'h00, 8'h01, -1);
    drain("drain_fcs68", 200);
    send(4, 8'h10, 8'h01, -1);
    repeat (4) @(posedge clk);
    chk("drop_fcs_short", {16'h0, drop_count}, 1);
    exp_q.push_back({4'b0001, 32'hAABBCCDD});
    exp_q.push_back({4'b0110, 32'hEE000000});
    send(9, 8'hAA, 8'h11, -1);
    exp_q.push_back({4'b0111, 32'h41000000});
    send(5, 8'h41, 8'h01, -1);
    drain("drain_fcs_small", 100);
    send_rst(12, 8'h60, 8'h01, -1, 5, 12);
    repeat (10) @(posedge clk);
    chk("midframe_rst_vld", {31'h0, rd_src_rdy}, 0);
    chk("midframe_rst_drop", {16'h0, drop_count}, 0);
    exp_q.push_back({4'b0001, 32'hAABBCCDD});
    exp_q.push_back({4'b0110, 32'hEE000000});
    send(9, 8'hAA, 8'h11, -1);
    drain("drain_fcs_after_rst", 100);
`else
    exp_q.push_back({4'b0001, 32'h01020304});
    exp_q.push_back({4'b0010, 32'h05060708});
    send(8, 8'h01, 8'h01, -1);
    exp_q.push_back({4'b0001, 32'hAABBCCDD});
    exp_q.push_back({4'b0110, 32'hEE000000});
    send(5, 8'hAA, 8'h11, -1);
    exp_q.push_back({4'b0111, 32'h41000000});
    send(1, 8'h41, 8'h01, -1);
    exp_q.push_back({4'b0011, 32'h10111213});
    send(4, 8'h10, 8'h01, -1);
    drain("drain_t123", 100);

    send(10, 8'h80, 8'h01, 3);
    exp_q.push_back({4'b0001, 32'h01020304});
    exp_q.push_back({4'b0010, 32'h05060708});
    send(8, 8'h01, 8'h01, -1);
    drain("drain_t4", 100);
    chk("drop_err", {16'h0, drop_count}, 1);

    rd_dst_rdy = 1'b0;
    push_gen(40, 8'h20, 8'h01);
    send(40, 8'h20, 8'h01, -1);
    send(60, 8'h90, 8'h01, -1);
    repeat (10) @(posedge clk);
    chk("drop_overflow", {16'h0, drop_count}, 2);
    chk("stall_vld", {31'h0, rd_src_rdy}, 1);
    chk("stall_q", exp_q.size(), 10);
    #1 rd_dst_rdy = 1'b1;
    drain("drain_t5", 100);

    push_gen(30, 8'h50, 8'h01);
    fork
      send(30, 8'h50, 8'h01, -1);
      begin
        repeat (120) begin
          @(posedge clk); #1;
          rd_dst_rdy = ~rd_dst_rdy;
        end
      end
    join
    #1 rd_dst_rdy = 1'b1;
    drain("drain_toggle", 100);

    send_rst(12, 8'h60, 8'h01, -1, 5, 12);
    repeat (10) @(posedge clk);
    chk("midframe_rst_vld", {31'h0, rd_src_rdy}, 0);
    chk("midframe_rst_drop", {16'h0, drop_count}, 0);
    exp_q.push_back({4'b0001, 32'hAABBCCDD});
    exp_q.push_back({4'b0110, 32'hEE000000});
    send(5, 8'hAA, 8'h11, -1);
    drain("drain_after_rst", 100);

    rd_dst_rdy = 1'b0;
    send(8, 8'h01, 8'h01, -1);
    chk("midread_vld", {31'h0, rd_src_rdy}, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    rd_dst_rdy = 1'b1;
    repeat (20) @(posedge clk);
    chk("midread_rst_vld", {31'h0, rd_src_rdy}, 0);
    exp_q.push_back({4'b0111, 32'h41000000});
    send(1, 8'h41, 8'h01, -1);
    drain("drain_final", 100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
